// File: rtl/ppu_vram_bus_arbiter.sv
// ppu_vram_bus_arbiter: shares the PPU multiplexed AD/ALE/RD/WR bus between render fetches and CPU $2007 accesses.
module ppu_vram_bus_arbiter #(
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        tick,
  input  logic        render_req,
  input  logic [13:0] render_addr,
  output logic        render_ack,
  output logic [7:0]  render_data,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [13:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_busy,
  output logic        cpu_done,
  output logic [7:0]  cpu_rdata,
  output logic [13:0] ad_out,
  output logic        ad_oe_lo,
  input  logic [7:0]  ad_in,
  output logic        ale,
  output logic        rd_n,
  output logic        wr_n,
  output logic        cpu_collision,
  input  logic        clr_err
);
  typedef enum logic [1:0] {IDLE, ADDR, ACCESS} state_t;
  localparam logic [7:0] LIM = 8'(STARVE_LIMIT);
  state_t      state_q, state_d;
  logic        gnt_cpu_q, gnt_cpu_d, gnt_we_q, gnt_we_d;
  logic [13:0] gnt_addr_q, gnt_addr_d;
  logic        pend_q, pend_d, busy_q, busy_d;
  logic        cpu_we_q, cpu_we_d;
  logic [13:0] cpu_addr_q, cpu_addr_d;
  logic [7:0]  cpu_wdata_q, cpu_wdata_d;
  logic [7:0]  starve_q, starve_d;
  logic        render_ack_q, render_ack_d, cpu_done_q, cpu_done_d;
  logic [7:0]  render_data_q, render_data_d, cpu_rdata_q, cpu_rdata_d;
  logic        coll_q, coll_d;
  logic        decide, win_r, in_acc, wr_acc;
  always_comb begin
    state_d       = state_q;
    gnt_cpu_d     = gnt_cpu_q;
    gnt_we_d      = gnt_we_q;
    gnt_addr_d    = gnt_addr_q;
    pend_d        = pend_q;
    busy_d        = busy_q;
    cpu_we_d      = cpu_we_q;
    cpu_addr_d    = cpu_addr_q;
    cpu_wdata_d   = cpu_wdata_q;
    starve_d      = starve_q;
    render_ack_d  = 1'b0;
    cpu_done_d    = 1'b0;
    render_data_d = render_data_q;
    cpu_rdata_d   = cpu_rdata_q;
    decide        = tick && (state_q == IDLE || state_q == ACCESS);
    win_r         = render_req && (starve_q < LIM);
    if (tick && state_q == ADDR) state_d = ACCESS;
    if (tick && state_q == ACCESS) begin
      if (gnt_cpu_q) begin
        cpu_done_d = 1'b1;
        busy_d     = 1'b0;
        if (!gnt_we_q) cpu_rdata_d = ad_in;
      end else begin
        render_ack_d  = 1'b1;
        render_data_d = ad_in;
      end
    end
    // A completing access re-arbitrates on the same edge so accesses run back to back.
    if (decide) begin
      state_d = IDLE;
      if (win_r) begin
        state_d    = ADDR;
        gnt_cpu_d  = 1'b0;
        gnt_we_d   = 1'b0;
        gnt_addr_d = render_addr;
        if (pend_q && starve_q != 8'hff) starve_d = starve_q + 8'd1;
      end else if (pend_q) begin
        state_d    = ADDR;
        gnt_cpu_d  = 1'b1;
        gnt_we_d   = cpu_we_q;
        gnt_addr_d = cpu_addr_q;
        pend_d     = 1'b0;
        starve_d   = 8'd0;
      end
    end
    if (cpu_req && !busy_q) begin
      pend_d      = 1'b1;
      busy_d      = 1'b1;
      cpu_we_d    = cpu_we;
      cpu_addr_d  = cpu_addr;
      cpu_wdata_d = cpu_wdata;
    end
    coll_d = clr_err ? 1'b0 : (coll_q | (cpu_req & busy_q));
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q       <= IDLE;
      gnt_cpu_q     <= 1'b0;
      gnt_we_q      <= 1'b0;
      gnt_addr_q    <= '0;
      pend_q        <= 1'b0;
      busy_q        <= 1'b0;
      cpu_we_q      <= 1'b0;
      cpu_addr_q    <= '0;
      cpu_wdata_q   <= '0;
      starve_q      <= '0;
      render_ack_q  <= 1'b0;
      cpu_done_q    <= 1'b0;
      render_data_q <= '0;
      cpu_rdata_q   <= '0;
      coll_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      gnt_cpu_q     <= gnt_cpu_d;
      gnt_we_q      <= gnt_we_d;
      gnt_addr_q    <= gnt_addr_d;
      pend_q        <= pend_d;
      busy_q        <= busy_d;
      cpu_we_q      <= cpu_we_d;
      cpu_addr_q    <= cpu_addr_d;
      cpu_wdata_q   <= cpu_wdata_d;
      starve_q      <= starve_d;
      render_ack_q  <= render_ack_d;
      cpu_done_q    <= cpu_done_d;
      render_data_q <= render_data_d;
      cpu_rdata_q   <= cpu_rdata_d;
      coll_q        <= coll_d;
    end
  end
  assign in_acc        = state_q == ACCESS;
  assign wr_acc        = in_acc && gnt_we_q;
  assign ale           = state_q == ADDR;
  assign ad_oe_lo      = ale || wr_acc;
  assign rd_n          = !(in_acc && !gnt_we_q);
  assign wr_n          = !wr_acc;
  assign ad_out        = state_q == IDLE ? 14'd0 : wr_acc ? {gnt_addr_q[13:8], cpu_wdata_q} : gnt_addr_q;
  assign render_ack    = render_ack_q;
  assign render_data   = render_data_q;
  assign cpu_busy      = busy_q;
  assign cpu_done      = cpu_done_q;
  assign cpu_rdata     = cpu_rdata_q;
  assign cpu_collision = coll_q;
endmodule

// File: tb/tb_ppu_vram_bus_arbiter.sv
// tb_ppu_vram_bus_arbiter: directed bench with a completion scoreboard for the VRAM bus arbiter.
module tb_ppu_vram_bus_arbiter;
  logic        CLK = 0, RST = 1, tick = 0, render_req = 0, cpu_req = 0, cpu_we = 0, clr_err = 0;
  logic [13:0] render_addr = 0, cpu_addr = 0;
  logic [7:0]  cpu_wdata = 0, ad_in = 0;
  logic        render_ack, cpu_busy, cpu_done, ad_oe_lo, ale, rd_n, wr_n, cpu_collision;
  logic [7:0]  render_data, cpu_rdata;
  logic [13:0] ad_out;
  typedef struct {bit cpu; logic [7:0] data;} exp_t;
  exp_t sb[$];
  int total = 0, bad = 0;

  ppu_vram_bus_arbiter #(.STARVE_LIMIT(8)) dut (
    .CLK(CLK), .RST(RST), .tick(tick), .render_req(render_req), .render_addr(render_addr),
    .render_ack(render_ack), .render_data(render_data), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_busy(cpu_busy), .cpu_done(cpu_done),
    .cpu_rdata(cpu_rdata), .ad_out(ad_out), .ad_oe_lo(ad_oe_lo), .ad_in(ad_in), .ale(ale),
    .rd_n(rd_n), .wr_n(wr_n), .cpu_collision(cpu_collision), .clr_err(clr_err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input bit c, input logic [7:0] d);
    sb.push_back('{c, d});
  endtask

  task automatic mon();
    exp_t e;
    if (render_ack || cpu_done) begin
      total++;
      assert (sb.size() != 0) else begin
        bad++;
        $error("FAIL unexpected_done observed render_ack=%0b cpu_done=%0b expected none", render_ack, cpu_done);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("done_kind", {render_ack, cpu_done}, {!e.cpu, e.cpu});
        chk("done_data", e.cpu ? cpu_rdata : render_data, e.data);
      end
    end
  endtask

  task automatic cyc(input bit t);
    tick = t;
    @(posedge CLK);
    #1;
    tick = 0;
    mon();
  endtask

  initial begin
    cyc(0);
    cyc(0);
    chk("rst_flags", {ale, rd_n, wr_n, ad_oe_lo, cpu_busy, render_ack, cpu_done, cpu_collision}, 8'b0110_0000);
    chk("rst_bus", {ad_out, render_data, cpu_rdata}, 0);
    RST = 0;
    cyc(1);
    chk("idle_ale", ale, 0);
    // CPU read from idle
    cpu_addr = 14'h2345; cpu_we = 0; cpu_req = 1;
    cyc(0);
    cpu_req = 0;
    chk("rd_busy", cpu_busy, 1);
    ad_in = 8'hA5;
    cyc(1);
    chk("rd_addr_ctl", {ale, ad_oe_lo, rd_n, wr_n}, 4'b1111);
    chk("rd_addr_bus", ad_out, 14'h2345);
    cyc(0);
    chk("rd_tick_gate", ale, 1);
    cyc(1);
    chk("rd_acc_ctl", {ale, ad_oe_lo, rd_n, wr_n}, 4'b0001);
    chk("rd_acc_hi", ad_out[13:8], 6'h23);
    push(1, 8'hA5);
    cyc(1);
    chk("rd_done", {cpu_done, cpu_busy}, 2'b10);
    cyc(0);
    chk("rd_pulse", {cpu_done, cpu_rdata}, {1'b0, 8'hA5});
    // CPU write
    cpu_addr = 14'h1FFF; cpu_wdata = 8'h3C; cpu_we = 1; cpu_req = 1;
    cyc(0);
    cpu_req = 0; ad_in = 8'hEE;
    cyc(1);
    chk("wr_addr_bus", ad_out, 14'h1FFF);
    chk("wr_addr_rdn", rd_n, 1);
    cyc(1);
    chk("wr_acc_bus", ad_out, 14'h1F3C);
    chk("wr_acc_ctl", {ale, ad_oe_lo, rd_n, wr_n}, 4'b0110);
    push(1, 8'hA5);
    cyc(1);
    chk("wr_done", {cpu_done, cpu_busy, rd_n}, 3'b101);
    // Back-to-back render reads
    render_addr = 14'h0010; render_req = 1;
    cyc(1);
    chk("b2b_addr1", {ale, ad_out}, {1'b1, 14'h0010});
    cyc(1);
    render_addr = 14'h0018; ad_in = 8'h31;
    push(0, 8'h31);
    cyc(1);
    chk("b2b_no_idle", {render_ack, ale, ad_out}, {2'b11, 14'h0018});
    render_req = 0;
    cyc(1);
    ad_in = 8'h32;
    push(0, 8'h32);
    cyc(1);
    chk("b2b_idle", {render_ack, ale, rd_n}, 3'b101);
    // Starvation override
    render_addr = 14'h0010; render_req = 1;
    cpu_addr = 14'h0100; cpu_we = 0; cpu_req = 1;
    cyc(0);
    cpu_req = 0;
    for (int j = 1; j <= 8; j++) push(0, 8'(2 * j + 1));
    push(1, 8'd19);
    push(0, 8'd21);
    push(0, 8'd23);
    for (int n = 1; n <= 23; n++) begin
      ad_in = 8'(n);
      if (n == 22) render_req = 0;
      cyc(1);
      if (n == 17) chk("starve_cpu_addr", {ale, ad_out}, {1'b1, 14'h0100});
      if (n == 19) chk("starve_back_render", {ale, ad_out}, {1'b1, 14'h0010});
    end
    chk("starve_sb_empty", sb.size(), 0);
    // Collision handling
    cpu_addr = 14'h0AAA; cpu_wdata = 8'h11; cpu_we = 1; cpu_req = 1;
    cyc(0);
    cpu_addr = 14'h0BBB; cpu_wdata = 8'h22; cpu_we = 0;
    cyc(0);
    cpu_req = 0;
    chk("coll_set", cpu_collision, 1);
    clr_err = 1;
    cyc(0);
    chk("coll_clr", cpu_collision, 0);
    cpu_req = 1;
    cyc(0);
    cpu_req = 0; clr_err = 0;
    chk("coll_clr_wins", cpu_collision, 0);
    cyc(1);
    chk("coll_keep_addr", ad_out, 14'h0AAA);
    cyc(1);
    chk("coll_keep_data", {wr_n, ad_out}, {1'b0, 14'h0A11});
    push(1, 8'd19);
    cyc(1);
    cpu_addr = 14'h0123; cpu_we = 0; cpu_req = 1;
    cyc(0);
    cpu_req = 0;
    chk("req_on_done", {cpu_busy, cpu_collision}, 2'b10);
    cyc(1);
    chk("req_on_done_addr", ad_out, 14'h0123);
    ad_in = 8'h77;
    cyc(1);
    push(1, 8'h77);
    cyc(1);
    // Async reset mid-ADDR of a CPU write
    cpu_addr = 14'h0555; cpu_wdata = 8'h66; cpu_we = 1; cpu_req = 1;
    cyc(0);
    cpu_req = 0;
    cyc(1);
    chk("mid_addr", ale, 1);
    #2 RST = 1;
    #1;
    chk("async_rst", {ale, rd_n, wr_n, ad_oe_lo, cpu_busy}, 5'b01100);
    @(posedge CLK);
    #1 RST = 0;
    for (int n = 0; n < 6; n++) cyc(1);
    chk("post_rst_idle", {cpu_busy, ale, wr_n}, 3'b001);
    chk("final_sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
